// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU memory port and mem_responder.
//
// Handshake: the initiator raises MemRead or MemWrite and holds it, together
// with a stable ADDR (and dataIn for writes), until it sees ready=1. ready is
// a registered one-cycle pulse. err, when set, coincides with that pulse, and
// MemOut is valid in the same cycle. The initiator drops its request in the
// ready cycle. A request that is still high in the following cycle is taken
// as a new request.
interface mem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] ADDR;
  logic [15:0] dataIn;
  logic [15:0] MemOut;
  logic        ready;
  logic        err;

  modport master (
    output MemRead, MemWrite, ADDR, dataIn,
    input  MemOut, ready, err
  );

  modport slave (
    input  MemRead, MemWrite, ADDR, dataIn,
    output MemOut, ready, err
  );
endinterface

// File: rtl/mem_responder.sv
// Wait-stated memory responder. It serves a RAM of 2^DEPTH_LOG2 16-bit words,
// an I/O output word at IO_BASE (reads return io_in), and a read-only access
// counter at IO_BASE+1. Each request runs IDLE -> WAIT x WAIT_CYCLES -> ACK.
// The access itself happens on the edge that enters ACK.
module mem_responder #(
  parameter int          DEPTH_LOG2  = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_BASE     = 16'hFF00
) (
  input  logic              CLK,
  input  logic              reset,
  mem_responder_if.slave    bus,
  input  logic [15:0]       io_in,
  output logic [15:0]       io_out,
  output logic [1:0]        fsm_state
);

  localparam int          RAM_WORDS = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_N    = 4'(WAIT_CYCLES);
  localparam logic [15:0] CNT_ADDR  = IO_BASE + 16'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        rd_q;
  logic        wr_q;
  logic [15:0] addr_q;
  logic [15:0] data_q;
  logic [15:0] acc_cnt;
  logic [15:0] mem_out;
  logic        ready_q;
  logic        err_q;

  logic [15:0] ram [RAM_WORDS];

  logic        req_in;
  logic        go_ack;
  logic        acc_rd;
  logic        acc_wr;
  logic [15:0] acc_addr;
  logic [15:0] acc_data;
  logic        hit_io;
  logic        hit_cnt;
  logic        hit_ram;
  logic        conflict;
  logic        acc_err;
  logic        ram_we;
  logic [DEPTH_LOG2-1:0] ram_idx;

  assign bus.MemOut = mem_out;
  assign bus.ready  = ready_q;
  assign bus.err    = err_q;
  assign fsm_state  = state;

  // Decode the access that happens on the edge entering ACK. With zero wait
  // states that edge leaves IDLE, so the live (stable) inputs stand in for
  // the not-yet-latched copies.
  always_comb begin
    req_in   = bus.MemRead | bus.MemWrite;
    go_ack   = ((state == IDLE) && req_in && (WAIT_N == 4'd0)) ||
               ((state == WAIT) && (wait_cnt == WAIT_N));
    acc_rd   = (state == IDLE) ? bus.MemRead  : rd_q;
    acc_wr   = (state == IDLE) ? bus.MemWrite : wr_q;
    acc_addr = (state == IDLE) ? bus.ADDR     : addr_q;
    acc_data = (state == IDLE) ? bus.dataIn   : data_q;
    hit_io   = (acc_addr == IO_BASE);
    hit_cnt  = (acc_addr == CNT_ADDR);
    hit_ram  = !hit_io && !hit_cnt &&
               ({16'd0, acc_addr} < 32'(RAM_WORDS));
    conflict = acc_rd && acc_wr;
    acc_err  = conflict || !(hit_io || hit_cnt || hit_ram);
    ram_idx  = acc_addr[DEPTH_LOG2-1:0];
    ram_we   = go_ack && acc_wr && !acc_rd && hit_ram && !reset;
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (ram_we) begin
      ram[ram_idx] <= acc_data;
    end
  end

  // Request FSM, access counter and registered outputs.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= 16'd0;
      data_q   <= 16'd0;
      acc_cnt  <= 16'd0;
      mem_out  <= 16'd0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      io_out   <= 16'd0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;

      if (go_ack) begin
        ready_q <= 1'b1;
        err_q   <= acc_err;
        acc_cnt <= acc_cnt + 16'd1;
        if (!conflict) begin
          if (acc_rd) begin
            if (hit_io)       mem_out <= io_in;
            else if (hit_cnt) mem_out <= acc_cnt;
            else if (hit_ram) mem_out <= ram[ram_idx];
            else              mem_out <= 16'd0;
          end else if (acc_wr && hit_io) begin
            io_out <= acc_data;
          end
        end
      end

      case (state)
        IDLE: begin
          if (req_in) begin
            rd_q   <= bus.MemRead;
            wr_q   <= bus.MemWrite;
            addr_q <= bus.ADDR;
            data_q <= bus.dataIn;
            if (WAIT_N == 4'd0) begin
              state <= ACK;
            end else begin
              state    <= WAIT;
              wait_cnt <= 4'd1;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == WAIT_N) state <= ACK;
          else                    wait_cnt <= wait_cnt + 4'd1;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder. Two instances share clock, reset and stimulus:
// dut0 has two wait states and dut1 has none. The sel input picks which
// instance receives requests and which one is observed.
module tb_mem_responder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sel;
  logic        req_rd;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_data;
  logic [15:0] io_in;
  logic [15:0] io_out0, io_out1;
  logic [1:0]  st0, st1;

  mem_responder_if bus0();
  mem_responder_if bus1();

  assign bus0.MemRead  = req_rd & ~sel;
  assign bus0.MemWrite = req_wr & ~sel;
  assign bus0.ADDR     = req_addr;
  assign bus0.dataIn   = req_data;
  assign bus1.MemRead  = req_rd & sel;
  assign bus1.MemWrite = req_wr & sel;
  assign bus1.ADDR     = req_addr;
  assign bus1.dataIn   = req_data;

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2), .IO_BASE(16'hFF00)) dut0 (
    .CLK(clk), .reset(reset), .bus(bus0), .io_in(io_in),
    .io_out(io_out0), .fsm_state(st0)
  );

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0), .IO_BASE(16'hFF00)) dut1 (
    .CLK(clk), .reset(reset), .bus(bus1), .io_in(io_in),
    .io_out(io_out1), .fsm_state(st1)
  );

  logic [15:0] obs_mem;
  logic        obs_ready;
  logic        obs_err;
  logic [15:0] obs_io;
  assign obs_mem   = sel ? bus1.MemOut : bus0.MemOut;
  assign obs_ready = sel ? bus1.ready  : bus0.ready;
  assign obs_err   = sel ? bus1.err    : bus0.err;
  assign obs_io    = sel ? io_out1     : io_out0;

  // ---------------- model + scoreboard ----------------
  logic [15:0] m_ram [256];
  logic [15:0] m_io;
  logic [15:0] m_cnt;
  logic [15:0] m_mem;
  logic [16:0] exp_q[$];   // {err, MemOut}

  int n_checks = 0;
  int n_pass   = 0;

  task automatic model_reset();
    m_io  = 16'd0;
    m_cnt = 16'd0;
    m_mem = 16'd0;
    exp_q.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req_rd = 1'b0;
    req_wr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Issue one request (caller sits 1 time unit after an edge), push the
  // model's expected {err, MemOut}, wait for ready, pop and compare.
  task automatic do_req(input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] d,
                        output int lat, output time t_rdy);
    logic        e_err;
    logic [16:0] exp_v;
    e_err = 1'b0;
    if (rd && wr) begin
      e_err = 1'b1;
    end else if (a == 16'hFF00) begin
      if (rd) m_mem = io_in;
      else    m_io  = d;
    end else if (a == 16'hFF01) begin
      if (rd) m_mem = m_cnt;
    end else if (a < 16'd256) begin
      if (rd) m_mem = m_ram[a[7:0]];
      else    m_ram[a[7:0]] = d;
    end else begin
      e_err = 1'b1;
      if (rd) m_mem = 16'd0;
    end
    m_cnt = m_cnt + 16'd1;
    exp_q.push_back({e_err, m_mem});

    req_rd = rd; req_wr = wr; req_addr = a; req_data = d;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!obs_ready && lat < 40);
    t_rdy = $time;
    req_rd = 1'b0;
    req_wr = 1'b0;

    exp_v = exp_q.pop_front();
    n_checks++;
    if (!obs_ready) begin
      $display("FAIL ready_timeout addr=%h: no ready within %0d edges", a, lat);
    end else if ({obs_err, obs_mem} !== exp_v) begin
      $display("FAIL response addr=%h rd=%b wr=%b: got err=%b MemOut=%h, expected err=%b MemOut=%h",
               a, rd, wr, obs_err, obs_mem, exp_v[16], exp_v[15:0]);
    end else begin
      n_pass++;
    end

    @(posedge clk);
    #1;
    n_checks++;
    if ({obs_ready, obs_err} !== 2'b00) begin
      $display("FAIL ready_width addr=%h: got ready=%b err=%b after ACK, expected 0 0",
               a, obs_ready, obs_err);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_checks++;
    if ({obs_mem, obs_ready, obs_err, obs_io} !== 34'd0) begin
      $display("FAIL reset_outputs: got MemOut=%h ready=%b err=%b io_out=%h, expected all 0",
               obs_mem, obs_ready, obs_err, obs_io);
    end else n_pass++;
  endtask

  task automatic test_ram_rw();
    int lat; time t;
    do_req(1'b0, 1'b1, 16'd5, 16'h1234, lat, t);
    n_checks++;
    if (lat !== 3) $display("FAIL write_latency: got %0d edges, expected 3", lat);
    else n_pass++;
    do_req(1'b1, 1'b0, 16'd5, 16'h0000, lat, t);
    n_checks++;
    if (lat !== 3) $display("FAIL read_latency: got %0d edges, expected 3", lat);
    else n_pass++;
    n_checks++;
    if (obs_mem !== 16'h1234) $display("FAIL read_hold: got %h, expected 1234", obs_mem);
    else n_pass++;
  endtask

  task automatic test_io();
    int lat; time t;
    do_req(1'b0, 1'b1, 16'hFF00, 16'hBEEF, lat, t);
    n_checks++;
    if (obs_io !== 16'hBEEF) $display("FAIL io_out: got %h, expected beef", obs_io);
    else n_pass++;
    io_in = 16'h00A5;
    do_req(1'b1, 1'b0, 16'hFF00, 16'h0000, lat, t);
    n_checks++;
    if (obs_mem !== 16'h00A5) $display("FAIL io_read: got %h, expected 00a5", obs_mem);
    else n_pass++;
  endtask

  task automatic test_unmapped();
    int lat; time t;
    do_req(1'b0, 1'b1, 16'd0, 16'h0A0A, lat, t);
    do_req(1'b1, 1'b0, 16'd5, 16'h0000, lat, t);
    do_req(1'b1, 1'b0, 16'h0400, 16'h0000, lat, t);
    n_checks++;
    if (obs_mem !== 16'h0000) $display("FAIL unmapped_read: got %h, expected 0000", obs_mem);
    else n_pass++;
    do_req(1'b0, 1'b1, 16'h0400, 16'hDEAD, lat, t);
    do_req(1'b1, 1'b0, 16'd0, 16'h0000, lat, t);
    n_checks++;
    if (obs_mem !== 16'h0A0A) $display("FAIL unmapped_write_alias: got %h, expected 0a0a", obs_mem);
    else n_pass++;
  endtask

  task automatic test_conflict();
    int lat; time t;
    do_req(1'b0, 1'b1, 16'd3, 16'h3333, lat, t);
    do_req(1'b1, 1'b0, 16'd5, 16'h0000, lat, t);
    do_req(1'b1, 1'b1, 16'd3, 16'h9999, lat, t);
    n_checks++;
    if (obs_mem !== 16'h1234) $display("FAIL conflict_memout: got %h, expected 1234", obs_mem);
    else n_pass++;
    do_req(1'b1, 1'b0, 16'd3, 16'h0000, lat, t);
    n_checks++;
    if (obs_mem !== 16'h3333) $display("FAIL conflict_ram: got %h, expected 3333", obs_mem);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat; time t;
    logic saw_ready;
    do_req(1'b0, 1'b1, 16'd7, 16'h7777, lat, t);
    do_req(1'b1, 1'b0, 16'd7, 16'h0000, lat, t);
    req_rd = 1'b0; req_wr = 1'b1; req_addr = 16'd7; req_data = 16'h5555;
    @(posedge clk);
    #1;
    n_checks++;
    if (st0 !== 2'd1) $display("FAIL mid_in_wait: got state %0d, expected 1", st0);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({obs_mem, obs_ready, obs_err, obs_io, st0} !== 36'd0) begin
      $display("FAIL async_reset: got MemOut=%h ready=%b err=%b io_out=%h state=%0d, expected all 0",
               obs_mem, obs_ready, obs_err, obs_io, st0);
    end else n_pass++;
    req_wr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    saw_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      saw_ready = saw_ready | obs_ready;
    end
    n_checks++;
    if (saw_ready !== 1'b0) $display("FAIL abandoned_ready: got ready pulse, expected none");
    else n_pass++;
    do_req(1'b1, 1'b0, 16'd7, 16'h0000, lat, t);
    n_checks++;
    if (obs_mem !== 16'h7777) $display("FAIL abandoned_write: got %h, expected 7777", obs_mem);
    else n_pass++;
  endtask

  task automatic test_counter();
    int lat; time t;
    apply_reset();
    do_req(1'b0, 1'b1, 16'd9, 16'h1111, lat, t);
    do_req(1'b1, 1'b0, 16'd9, 16'h0000, lat, t);
    do_req(1'b0, 1'b1, 16'hFF00, 16'h0042, lat, t);
    do_req(1'b1, 1'b0, 16'hFF01, 16'h0000, lat, t);
    n_checks++;
    if (obs_mem !== 16'd3) $display("FAIL counter: got %0d, expected 3", obs_mem);
    else n_pass++;
    do_req(1'b0, 1'b1, 16'hFF01, 16'hFFFF, lat, t);
    do_req(1'b1, 1'b0, 16'hFF01, 16'h0000, lat, t);
    n_checks++;
    if (obs_mem !== 16'd5) $display("FAIL counter_ro: got %0d, expected 5", obs_mem);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat; time t1, t2;
    do_req(1'b1, 1'b0, 16'd9, 16'h0000, lat, t1);
    do_req(1'b0, 1'b1, 16'd10, 16'h2222, lat, t2);
    n_checks++;
    if ((t2 - t1) !== 40) $display("FAIL b2b_period_w2: got %0t, expected 40", t2 - t1);
    else n_pass++;
  endtask

  task automatic test_zero_wait();
    int lat; time t1, t2;
    sel = 1'b1;
    apply_reset();
    do_req(1'b0, 1'b1, 16'd5, 16'h1234, lat, t1);
    n_checks++;
    if (lat !== 1) $display("FAIL w0_write_latency: got %0d edges, expected 1", lat);
    else n_pass++;
    do_req(1'b1, 1'b0, 16'd5, 16'h0000, lat, t2);
    n_checks++;
    if (lat !== 1) $display("FAIL w0_read_latency: got %0d edges, expected 1", lat);
    else n_pass++;
    n_checks++;
    if ((t2 - t1) !== 20) $display("FAIL b2b_period_w0: got %0t, expected 20", t2 - t1);
    else n_pass++;
    do_req(1'b1, 1'b1, 16'd5, 16'h0BAD, lat, t1);
    do_req(1'b1, 1'b0, 16'hFF01, 16'h0000, lat, t1);
    n_checks++;
    if (obs_mem !== 16'd3) $display("FAIL w0_counter: got %0d, expected 3", obs_mem);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] a, d;
      a = 16'($urandom_range(0, 255));
      d = 16'($urandom_range(0, 65535));
      do_req(1'b0, 1'b1, a, d, lat, t1);
      do_req(1'b1, 1'b0, a, 16'h0000, lat, t1);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    reset    = 1'b1;
    sel      = 1'b0;
    req_rd   = 1'b0;
    req_wr   = 1'b0;
    req_addr = 16'd0;
    req_data = 16'd0;
    io_in    = 16'h0000;
    apply_reset();
    test_reset();
    test_ram_rw();
    test_io();
    test_unmapped();
    test_conflict();
    test_reset_mid();
    test_counter();
    test_back_to_back();
    test_zero_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
